// File: rtl/avalon_onchip_ram_pipelined_pkg.sv
// Shared definitions for the pipelined Avalon-MM on-chip RAM.
//   state_e          : controller states (CLEAR zero-fills the array, READY serves traffic)
//   RL_MIN / RL_MAX  : legal read latency range
//   clamp_latency()  : maps a requested latency onto the legal range
package avalon_onchip_ram_pipelined_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 2;

  function automatic int clamp_latency(input int rl);
    return (rl >= RL_MAX) ? RL_MAX : RL_MIN;
  endfunction

endpackage

// File: rtl/avalon_onchip_ram_pipelined_ram_sp_be.sv
// Inferred single-port RAM with per-byte write enables and a registered,
// read-first output. No reset: contents only change through writes.
//   clk_i   : clock
//   we_i    : per-byte write enable (one bit per 8-bit lane)
//   addr_i  : word address shared by read and write
//   wdata_i : write data
//   rdata_o : mem[addr_i] as it was before this edge's write, one cycle later
module ram_sp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input  logic                  clk_i,
  input  logic [DATA_W/8-1:0]   we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (we_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/avalon_onchip_ram_pipelined.sv
// Avalon-MM slave on-chip RAM with optional zero-fill after reset,
// debug-qualified writes and a 1- or 2-cycle pipelined read path.
//   clk, reset                         : clock, async active-high reset
//   address/byteenable/chipselect/read/write/writedata/debugaccess : slave inputs
//   readdata/readdatavalid/waitrequest : slave outputs
//   init_done                          : high once the zero-fill has finished (or was skipped)
module avalon_onchip_ram_pipelined
  import avalon_onchip_ram_pipelined_pkg::*;
#(
  parameter int DATA_W            = 32,
  parameter int ADDR_W            = 14,
  parameter int READ_LATENCY      = 1,
  parameter int CLEAR_ON_RESET    = 1,
  parameter int WRITE_NEEDS_DEBUG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                debugaccess,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                init_done
);

  localparam int     NB        = DATA_W / 8;
  localparam int     RL        = clamp_latency(READ_LATENCY);
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
  localparam bit     WR_GATED  = (WRITE_NEEDS_DEBUG != 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              init_done_q;

  logic              acc_rd, acc_wr, wr_commit;
  logic [NB-1:0]     ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic              vld_p1_q;
  logic [DATA_W-1:0] out_q;

  // waitrequest is decoded straight from the state register so it already
  // reflects the reset state while reset is held.
  assign waitrequest = (state_q == ST_CLEAR);
  assign init_done   = init_done_q;

  // Simultaneous read+write is a write; the read side is suppressed.
  assign acc_rd    = chipselect & ~waitrequest & read & ~write;
  assign acc_wr    = chipselect & ~waitrequest & write;
  assign wr_commit = acc_wr & (debugaccess | ~WR_GATED);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ram_we    = '0;
    ram_addr  = address;
    ram_wdata = writedata;
    if (state_q == ST_CLEAR) begin
      ram_we    = '1;
      ram_addr  = clr_cnt_q;
      ram_wdata = '0;
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == '1) state_d = ST_READY;
    end else if (wr_commit) begin
      ram_we = byteenable;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RST_STATE;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= (state_d == ST_READY);
    end
  end

  ram_sp_be #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Stage p1: RAM output valid; out_q keeps the last returned word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      out_q    <= '0;
    end else begin
      vld_p1_q <= acc_rd;
      if (vld_p1_q) out_q <= ram_rdata;
    end
  end

  generate
    if (RL == 2) begin : g_lat2
      // Stage p2: out_q acts as the second output register.
      logic vld_p2_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_p2_q <= 1'b0;
        else       vld_p2_q <= vld_p1_q;
      end
      assign readdatavalid = vld_p2_q;
      assign readdata      = out_q;
    end else begin : g_lat1
      // Bypass the RAM word on the valid cycle, otherwise show the held word.
      assign readdatavalid = vld_p1_q;
      assign readdata      = vld_p1_q ? ram_rdata : out_q;
    end
  endgenerate

endmodule

// File: tb/tb_avalon_onchip_ram_pipelined.sv
module tb_avalon_onchip_ram_pipelined;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] address = '0;
  logic [3:0]    byteenable = '0;
  logic          chipselect = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [DW-1:0] writedata = '0;
  logic          debugaccess = 1'b0;

  logic [DW-1:0] rdata1, rdata2;
  logic          rv1, rv2, wr1, wr2, id1, id2;

  always #5 clk = ~clk;

  avalon_onchip_ram_pipelined #(
    .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1), .WRITE_NEEDS_DEBUG(1)
  ) u_dut_l1 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .debugaccess(debugaccess), .readdata(rdata1), .readdatavalid(rv1),
    .waitrequest(wr1), .init_done(id1)
  );

  avalon_onchip_ram_pipelined #(
    .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1), .WRITE_NEEDS_DEBUG(1)
  ) u_dut_l2 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .debugaccess(debugaccess), .readdata(rdata2), .readdatavalid(rv2),
    .waitrequest(wr2), .init_done(id2)
  );

  // Reference model: word array, pending-read queues with due cycle, clear countdown.
  typedef struct {
    int          due;
    logic [31:0] d;
  } rd_t;

  rd_t         q1[$];
  rd_t         q2[$];
  logic [31:0] mem [DEPTH];
  int          clear_left = DEPTH;
  int          cyc = 0;
  logic [31:0] last1 = '0;
  logic [31:0] last2 = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit v1, v2;
    v1 = (q1.size() > 0) && (q1[0].due == cyc);
    v2 = (q2.size() > 0) && (q2[0].due == cyc);
    if (v1) begin last1 = q1[0].d; void'(q1.pop_front()); end
    if (v2) begin last2 = q2[0].d; void'(q2.pop_front()); end
    chk("rdvalid_l1", {31'b0, rv1}, {31'b0, v1});
    chk("rdata_l1",   rdata1,       last1);
    chk("rdvalid_l2", {31'b0, rv2}, {31'b0, v2});
    chk("rdata_l2",   rdata2,       last2);
    chk("waitreq_l1", {31'b0, wr1}, {31'b0, (clear_left > 0)});
    chk("waitreq_l2", {31'b0, wr2}, {31'b0, (clear_left > 0)});
    chk("initdone_l1", {31'b0, id1}, {31'b0, (clear_left == 0) && !reset});
    chk("initdone_l2", {31'b0, id2}, {31'b0, (clear_left == 0) && !reset});
  endtask

  // One bus cycle: drive at negedge, update model at posedge, check 1 ns later.
  task automatic step(input logic cs, input logic rd, input logic wr, input logic [3:0] a,
                      input logic [3:0] be, input logic [31:0] wd, input logic dbg);
    rd_t e;
    chipselect  = cs;
    read        = rd;
    write       = wr;
    address     = a;
    byteenable  = be;
    writedata   = wd;
    debugaccess = dbg;
    @(posedge clk);
    cyc++;
    if (!reset) begin
      if (clear_left == 0) begin
        if (cs && wr) begin
          if (dbg) begin
            for (int b = 0; b < 4; b++)
              if (be[b]) mem[a][b*8 +: 8] = wd[b*8 +: 8];
          end
        end else if (cs && rd) begin
          e.d = mem[a];
          e.due = cyc;     q1.push_back(e);
          e.due = cyc + 1; q2.push_back(e);
        end
      end else begin
        clear_left--;
        if (clear_left == 0)
          for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      end
    end
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0);
  endtask

  // Asynchronous assertion between edges, held for two edges, released at a negedge.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    q1.delete();
    q2.delete();
    last1 = '0;
    last2 = '0;
    clear_left = DEPTH;
    check_outputs();
    @(negedge clk);
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    @(negedge clk);

    // Reset, then zero-fill: 16 waitrequest cycles, then all reads return 0.
    pulse_reset();
    idle(DEPTH);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, i[3:0], 4'hF, 32'd0, 1'b0);
    idle(3);

    // Full write then byte-lane merge.
    step(1'b1, 1'b0, 1'b1, 4'd5, 4'hF, 32'hDEADBEEF, 1'b1);
    step(1'b1, 1'b0, 1'b1, 4'd5, 4'h1, 32'h000000AA, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'd5, 4'h0, 32'd0, 1'b0);
    idle(3);

    // Write dropped without debugaccess; committed with it; read right after write.
    step(1'b1, 1'b0, 1'b1, 4'd3, 4'hF, 32'h12345678, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'd3, 4'h0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'd3, 4'hF, 32'h12345678, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'd3, 4'h0, 32'd0, 1'b0);
    idle(3);

    // Back-to-back reads.
    step(1'b1, 1'b1, 1'b0, 4'd1, 4'h0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'd2, 4'h0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'd3, 4'h0, 32'd0, 1'b0);
    idle(3);

    // Read+write together counts as write only; byteenable=0 leaves the word.
    step(1'b1, 1'b1, 1'b1, 4'd9, 4'hF, 32'h00000055, 1'b1);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 4'd9, 4'h0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'd9, 4'h0, 32'hFFFFFFFF, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'd9, 4'h0, 32'd0, 1'b0);
    idle(3);

    // In-flight read completes after chipselect drops (read still high).
    step(1'b1, 1'b1, 1'b0, 4'd5, 4'h0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd7, 4'h0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd7, 4'h0, 32'd0, 1'b0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      step(r[1:0] != 2'b00, r[2], r[4:3] == 2'b00, r[8:5], r[12:9], $urandom, r[13] | r[14]);
    end
    idle(3);

    // Reset while a read is in flight: no stale readdatavalid afterwards.
    step(1'b1, 1'b1, 1'b0, 4'd9, 4'h0, 32'd0, 1'b0);
    pulse_reset();

    // Reset again at clear count 7; clear restarts, traffic during clear ignored.
    idle(7);
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom;
      step(1'b1, r[0], r[1], r[5:2], 4'hF, $urandom, 1'b1);
    end
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, i[3:0], 4'h0, 32'd0, 1'b0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
